// File: rtl/ram_bridge_pkg.sv
// ram_bridge_pkg: shared definitions for the rvcpu-to-RAMHelper bridge.
// Holds the access size encodings, the bridge FSM state type and the
// default address map (RAM base equals the core's reset PC).
package ram_bridge_pkg;

  localparam logic [63:0] PC_START      = 64'h8000_0000;
  localparam logic [63:0] BASE_ADDR_DEF = PC_START;
  localparam logic [63:0] UART_ADDR_DEF = 64'h1000_0000;

  // Access size encodings as carried on req_size_i; 4..7 are illegal.
  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;
  localparam logic [2:0] SIZE_D = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Number of bytes touched by a legal size code.
  function automatic logic [3:0] size_nbytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/ram_lane_align.sv
// ram_lane_align: byte-lane steering between a right-aligned core access
// and a 64-bit RAM word. Purely combinational: builds the 64-bit write
// mask, shifts write data into its lanes and extracts/zero-extends read
// data. Only the legal size codes (0..3) are presented here.
module ram_lane_align
  import ram_bridge_pkg::*;
(
  input  logic [2:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rdata,
  output logic [63:0] o_wmask,
  output logic [63:0] o_wdata,
  output logic [63:0] o_rdata
);

  logic [7:0]  w_lanes;
  logic [63:0] w_keep;
  logic [7:0]  w_bmask;
  logic [5:0]  w_shift;

  assign w_shift = {i_off, 3'b000};

  // Per-size byte-lane pattern (before offset) and read-data keep mask.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch.
    w_lanes = 8'h01;
    w_keep  = 64'h0000_0000_0000_00FF;
    case ({1'b0, i_size})
      SIZE_B: begin
        w_lanes = 8'h01;
        w_keep  = 64'h0000_0000_0000_00FF;
      end
      SIZE_H: begin
        w_lanes = 8'h03;
        w_keep  = 64'h0000_0000_0000_FFFF;
      end
      SIZE_W: begin
        w_lanes = 8'h0F;
        w_keep  = 64'h0000_0000_FFFF_FFFF;
      end
      SIZE_D: begin
        w_lanes = 8'hFF;
        w_keep  = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      default: ;
    endcase
  end

  assign w_bmask = w_lanes << i_off;

  for (genvar g = 0; g < 8; g++) begin : g_lane
    assign o_wmask[g*8 +: 8] = {8{w_bmask[g]}};
  end

  assign o_wdata = i_wdata << w_shift;
  assign o_rdata = (i_rdata >> w_shift) & w_keep;

endmodule

// File: rtl/ram_bridge.sv
// ram_bridge: single-outstanding bridge from the rvcpu ram_rw request port
// to the RAMHelper simulation memory. Each request is latched in IDLE,
// performs one RAM access cycle (ACCESS) and returns a one-cycle ready
// pulse (RESP). Illegal size, dword-crossing and out-of-window accesses
// complete with resp_err_o and never touch the RAM.
// Optional build macro RAM_BRIDGE_UART_EN: byte writes to UART_ADDR are
// diverted to the uart_out_* strobe, reads of UART_ADDR return 0.
module ram_bridge
  import ram_bridge_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int          IDX_W     = 16,
  parameter logic [63:0] UART_ADDR = UART_ADDR_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_cen_i,
  input  logic             req_wen_i,
  input  logic [63:0]      req_addr_i,
  input  logic [63:0]      req_wdata_i,
  input  logic [2:0]       req_size_i,
  output logic             resp_ready_o,
  output logic [63:0]      resp_data_o,
  output logic             resp_err_o,
  output logic             ram_en_o,
  output logic             ram_wen_o,
  output logic [IDX_W-1:0] ram_ridx_o,
  output logic [IDX_W-1:0] ram_widx_o,
  output logic [63:0]      ram_wdata_o,
  output logic [63:0]      ram_wmask_o,
  input  logic [63:0]      ram_rdata_i,
  output logic             uart_out_valid_o,
  output logic [7:0]       uart_out_ch_o
);

`ifdef RAM_BRIDGE_UART_EN
  localparam bit UART_EN = 1'b1;
`else
  localparam bit UART_EN = 1'b0;
`endif

  state_t           r_state;
  logic             r_wen;
  logic [63:0]      r_addr;
  logic [63:0]      r_wdata;
  logic [2:0]       r_size;
  logic             r_ram_en;
  logic             r_ram_wen;
  logic [IDX_W-1:0] r_ram_idx;
  logic [63:0]      r_ram_wdata;
  logic [63:0]      r_ram_wmask;
  logic             r_resp_ready;
  logic             r_resp_err;
  logic [63:0]      r_resp_data;

  // In IDLE the decode looks at the incoming request so the RAM outputs can
  // be registered on acceptance; afterwards it looks at the latched request.
  logic [63:0] w_addr;
  logic [63:0] w_wdata;
  logic [2:0]  w_size;
  logic [2:0]  w_off;
  logic [3:0]  w_nbytes;
  logic        w_cross;
  logic        w_below;
  logic [63:0] w_word;
  logic        w_oor;
  logic        w_ram_err;
  logic        w_is_uart;
  logic        w_err;
  logic        w_ram_ok;
  logic [63:0] w_wmask;
  logic [63:0] w_wdata_sh;
  logic [63:0] w_rdata_ext;

  assign w_addr  = (r_state == ST_IDLE) ? req_addr_i  : r_addr;
  assign w_wdata = (r_state == ST_IDLE) ? req_wdata_i : r_wdata;
  assign w_size  = (r_state == ST_IDLE) ? req_size_i  : r_size;

  assign w_off     = w_addr[2:0];
  assign w_nbytes  = size_nbytes(w_size[1:0]);
  assign w_cross   = ({1'b0, w_off} + w_nbytes) > 4'd8;
  assign w_below   = w_addr < BASE_ADDR;
  assign w_word    = (w_addr - BASE_ADDR) >> 3;
  assign w_oor     = (w_word >> IDX_W) != 64'd0;
  assign w_ram_err = w_size[2] | w_cross | w_below | w_oor;

  // The UART register only accepts byte accesses; it never reaches the RAM.
  assign w_is_uart = UART_EN && (w_addr == UART_ADDR);
  assign w_err     = w_is_uart ? (w_size != SIZE_B) : w_ram_err;
  assign w_ram_ok  = !w_is_uart && !w_ram_err;

  ram_lane_align u_align (
    .i_off   (w_off),
    .i_size  (w_size[1:0]),
    .i_wdata (w_wdata),
    .i_rdata (ram_rdata_i),
    .o_wmask (w_wmask),
    .o_wdata (w_wdata_sh),
    .o_rdata (w_rdata_ext)
  );

  // Request FSM: latch in IDLE, one RAM cycle in ACCESS, ready pulse in RESP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_wen        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= '0;
      r_ram_en     <= 1'b0;
      r_ram_wen    <= 1'b0;
      r_ram_idx    <= '0;
      r_ram_wdata  <= '0;
      r_ram_wmask  <= '0;
      r_resp_ready <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from
      // pre-edge values regardless of statement order.
      case (r_state)
        ST_IDLE: begin
          if (req_cen_i) begin
            r_wen   <= req_wen_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_size  <= req_size_i;
            if (w_ram_ok) begin
              r_ram_en    <= 1'b1;
              r_ram_wen   <= req_wen_i;
              r_ram_idx   <= w_word[IDX_W-1:0];
              r_ram_wdata <= w_wdata_sh;
              r_ram_wmask <= w_wmask;
            end
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_ram_en     <= 1'b0;
          r_ram_wen    <= 1'b0;
          r_resp_ready <= 1'b1;
          r_resp_err   <= w_err;
          if (w_err || (w_is_uart && !r_wen)) begin
            r_resp_data <= '0;
          end else if (!r_wen) begin
            r_resp_data <= w_rdata_ext;
          end
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_resp_ready <= 1'b0;
          r_resp_err   <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign resp_ready_o = r_resp_ready;
  assign resp_data_o  = r_resp_data;
  assign resp_err_o   = r_resp_err;
  assign ram_en_o     = r_ram_en;
  assign ram_wen_o    = r_ram_wen;
  assign ram_ridx_o   = r_ram_idx;
  assign ram_widx_o   = r_ram_idx;
  assign ram_wdata_o  = r_ram_wdata;
  assign ram_wmask_o  = r_ram_wmask;

`ifdef RAM_BRIDGE_UART_EN
  logic       r_uart_valid;
  logic [7:0] r_uart_ch;

  // UART strobe: raised on acceptance of a byte write to UART_ADDR, so it
  // is high exactly for that request's ACCESS cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_uart_valid <= 1'b0;
      r_uart_ch    <= 8'h00;
    end else if (r_state == ST_IDLE && req_cen_i && w_is_uart &&
                 req_wen_i && req_size_i == SIZE_B) begin
      r_uart_valid <= 1'b1;
      r_uart_ch    <= req_wdata_i[7:0];
    end else if (r_state == ST_ACCESS) begin
      r_uart_valid <= 1'b0;
    end
  end

  assign uart_out_valid_o = r_uart_valid;
  assign uart_out_ch_o    = r_uart_ch;
`else
  assign uart_out_valid_o = 1'b0;
  assign uart_out_ch_o    = 8'h00;
`endif

endmodule

// File: doc/ram_bridge.md
Name: ram_bridge

Overview:
- Sits between the rvcpu core's ram_rw request port and the RAMHelper simulation memory in SimTop.
- Latches one core request at a time and translates the byte address into a 64-bit-word index relative to BASE_ADDR.
- Aligns write data and byte masks from size and offset, performs the RAMHelper access, extracts and zero-extends read data.
- Returns a one-cycle ready pulse with data or an error flag.

Parameters:
- BASE_ADDR, 64'h8000_0000, byte address mapped to RAM index 0.
- IDX_W, 16, width of the RAM word index; the addressable range is 2^IDX_W 64-bit words.
- UART_ADDR, 64'h1000_0000, MMIO byte address of the UART transmit register (used only with the optional feature).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_cen_i  in  1  request valid; held by core until resp_ready_o
- req_wen_i  in  1  1=write, 0=read
- req_addr_i  in  64  byte address
- req_wdata_i  in  64  write data, right-aligned (LSB = first byte)
- req_size_i  in  3  0=byte, 1=half, 2=word, 3=dword, 4..7 illegal
- resp_ready_o  out  1  one-cycle completion pulse
- resp_data_o  out  64  read data, right-aligned, zero-extended
- resp_err_o  out  1  valid with resp_ready_o; access was rejected
- ram_en_o  out  1  RAMHelper enable
- ram_wen_o  out  1  RAMHelper write enable
- ram_ridx_o  out  IDX_W  read index
- ram_widx_o  out  IDX_W  write index (equal to ram_ridx_o)
- ram_wdata_o  out  64  lane-shifted write data
- ram_wmask_o  out  64  bit mask (byte lanes expanded ×8)
- ram_rdata_i  in  64  combinational read data for ram_ridx_o
- uart_out_valid_o  out  1  UART byte strobe
- uart_out_ch_o  out  8  UART byte

Behaviour:
- Reset: state IDLE; every output 0; request registers cleared. Reset in any state aborts the access with no ready pulse.
- FSM states and transitions:
  - IDLE: when req_cen_i=1, capture wen, addr, wdata and size into registers and go to ACCESS. Otherwise stay.
  - ACCESS, 1 cycle:
    - If the request is legal RAM, drive ram_en_o=1, ram_wen_o=wen and the index/data/mask.
    - For a legal read, capture ram_rdata_i shifted right by off*8 and masked to the size width into the data register.
    - Go to RESP.
  - RESP, 1 cycle: resp_ready_o=1, resp_data_o/resp_err_o valid. Go to IDLE unconditionally.
- Handshake rules:
  - req_cen_i is ignored outside IDLE.
  - The core must drop or replace its request in the cycle after it sees ready. A request still high in IDLE is treated as a new request.
  - Latency from acceptance edge to ready pulse is exactly 2 cycles; throughput is 1 request per 3 cycles.
- Address and lane arithmetic:
  - off = addr[2:0]; nbytes = 1<<size.
  - Index = (addr − BASE_ADDR) >> 3, truncated to IDX_W.
  - Byte mask = ((1<<nbytes)−1) << off, 8 bits, expanded to 64-bit ram_wmask_o.
  - ram_wdata_o = wdata << (off*8).
- Error conditions (set resp_err_o=1, ram_en_o stays 0, resp_data_o=0):
  - size > 3;
  - off + nbytes > 8 (the access crosses a dword);
  - addr < BASE_ADDR;
  - (addr − BASE_ADDR) >> 3 ≥ 2^IDX_W.
- Outputs outside ACCESS: ram_en_o and ram_wen_o are 0; index, data and mask hold their last values.
- resp_data_o holds its value after RESP until the next read completes. resp_err_o is 0 outside RESP.

Optional Feature:
- Macro: RAM_BRIDGE_UART_EN.
- When defined:
  - A legal-size byte write to UART_ADDR produces no RAM access; uart_out_valid_o=1 for the ACCESS cycle only, with uart_out_ch_o = wdata[7:0].
  - A read of UART_ADDR returns 0 with no error.
  - Any non-byte access to UART_ADDR is an error.
- When undefined: UART_ADDR is an ordinary address (out of range by default, so it errors); uart_out_valid_o and uart_out_ch_o are tied to 0.

Decomposition:
- Shared package/defines holds:
  - size encodings SIZE_B/H/W/D;
  - the FSM state typedef (IDLE/ACCESS/RESP);
  - BASE_ADDR default (same value as PC_START).
- One natural sub-module, ram_lane_align: purely combinational; computes the byte mask, shifted write data and extracted read data from off and size.
- The FSM, error checks and registers stay in ram_bridge.

Test Plan:
- Dword write 0x1122334455667788 at 0x8000_0008 → ACCESS cycle shows ram_en_o=1, ram_wen_o=1, ram_widx_o=1, ram_wmask_o=all ones; resp_ready_o pulses 2 cycles after acceptance; resp_err_o=0.
- Byte write 0xAB at 0x8000_0003 → ram_widx_o=0, ram_wmask_o=64'h0000_0000_FF00_0000, ram_wdata_o[31:24]=0xAB.
- Half read at 0x8000_0006 with ram_rdata_i=64'hDEAD_BEEF_CAFE_1234 → resp_data_o=64'h0000_0000_0000_DEAD.
- Word access at 0x8000_0006, size=7 at 0x8000_0000, and dword access at 0x7FFF_FFF8 → each gives resp_err_o=1, resp_data_o=0, ram_en_o never asserted.
- req_cen_i held high for 7 cycles → exactly 2 completions (the requests accepted in cycles 0 and 3), plus a 3rd accepted in cycle 6 and still in progress when req_cen_i drops; no RAM activity in RESP cycles.
- Assert reset during ACCESS of a write → all outputs 0 immediately; no ready pulse; the next request after reset completes normally.
- With RAM_BRIDGE_UART_EN: byte write 0x41 to 0x1000_0000 → uart_out_valid_o=1 for one cycle, uart_out_ch_o=0x41, ram_en_o=0.
